// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit seven-segment driver with tear-free double buffering and an
// anti-ghosting blank guard. Define SSEG_LZ_BLANK_EN to enable leading-zero blanking.
module seven_seg_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 1000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  dp,
  output logic                  pending,
  output logic                  frame_tick
);

  localparam int   DIV_W = $clog2(REFRESH_DIV);
  localparam int   IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic POL   = (ACTIVE_LOW != 0);

  logic [DIV_W-1:0]    div_p0;
  logic [IDX_W-1:0]    idx_p0;
  logic [4*DIGITS-1:0] stage_val;
  logic [DIGITS-1:0]   stage_dp;
  logic [4*DIGITS-1:0] disp_val;
  logic [DIGITS-1:0]   disp_dp;

  logic       slot_end;
  logic       last_digit;
  logic       boundary;
  logic       in_guard;
  logic [3:0] nib;
  logic       blank;

  function automatic logic [6:0] hex_decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign slot_end   = (div_p0 == DIV_W'(REFRESH_DIV - 1));
  assign last_digit = (idx_p0 == IDX_W'(DIGITS - 1));
  assign boundary   = slot_end && last_digit;
  assign in_guard   = (div_p0 < DIV_W'(GUARD));
  assign nib        = disp_val[4*idx_p0 +: 4];

`ifdef SSEG_LZ_BLANK_EN
  // A digit is blank when it and every digit above it are zero, unless its dp is lit.
  always_comb begin
    logic zero_above;
    blank      = 1'b0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (disp_val[4*i +: 4] == 4'h0);
      if (i == int'(idx_p0))
        blank = (i != 0) && zero_above && !disp_dp[i];
    end
  end
`else
  assign blank = 1'b0;
`endif

  // Stage 0: scan counters, staging and display buffers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_p0     <= '0;
      idx_p0     <= '0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
      stage_val  <= '0;
      stage_dp   <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
    end else begin
      div_p0     <= slot_end ? '0 : div_p0 + DIV_W'(1);
      frame_tick <= boundary;
      if (slot_end)
        idx_p0 <= last_digit ? '0 : idx_p0 + IDX_W'(1);
      if (load) begin
        stage_val <= value;
        stage_dp  <= dp_in;
      end
      if (boundary) begin
        if (load) begin
          disp_val <= value;
          disp_dp  <= dp_in;
        end else if (pending) begin
          disp_val <= stage_val;
          disp_dp  <= stage_dp;
        end
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // Stage 1: registered pin drivers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg <= {7{POL}};
      an  <= {DIGITS{POL}};
      dp  <= POL;
    end else if (in_guard) begin
      seg <= {7{POL}};
      an  <= {DIGITS{POL}};
      dp  <= POL;
    end else begin
      seg <= {7{POL}} ^ (blank ? 7'h00 : hex_decode(nib));
      an  <= {DIGITS{POL}} ^ (DIGITS'(1) << idx_p0);
      dp  <= POL ^ disp_dp[idx_p0];
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomised and directed bench for seven_seg_scan against a time-based reference model.
module tb_seven_seg_scan;
  localparam int DIGITS = 4;
  localparam int RD     = 4;
  localparam int GUARD  = 1;
  localparam int FRAME  = DIGITS * RD;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        pending;
  logic        frame_tick;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seven_seg_scan #(.DIGITS(DIGITS), .REFRESH_DIV(RD), .GUARD(GUARD), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset_n(reset_n), .value(value), .dp_in(dp_in), .load(load),
    .seg(seg), .an(an), .dp(dp), .pending(pending), .frame_tick(frame_tick)
  );

  logic [6:0] hex7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: time since reset release, staged and displayed words
  int          m_t;
  logic [15:0] m_stage, m_disp;
  logic [3:0]  m_sdp, m_ddp;
  logic        m_pend;
  logic [6:0]  e_seg;
  logic [3:0]  e_an;
  logic        e_dp, e_tick;
  logic [6:0]  obs_seg [4];
  logic        obs_dp [4];
  logic        saw_one;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_t = 0; m_stage = '0; m_disp = '0; m_sdp = '0; m_ddp = '0; m_pend = 1'b0;
  endtask

  function automatic logic [6:0] zero_digit(input int d);
`ifdef SSEG_LZ_BLANK_EN
    return (d == 0) ? 7'h40 : 7'h7F;
`else
    return 7'h40;
`endif
  endfunction

  task automatic model_edge();
    int ph, dg;
    bit bnd, blank;
    logic [3:0] nib;
    ph  = m_t % RD;
    dg  = (m_t / RD) % DIGITS;
    bnd = (m_t % FRAME) == FRAME - 1;
    nib = m_disp[4*dg +: 4];
    blank = 1'b0;
`ifdef SSEG_LZ_BLANK_EN
    blank = (dg != 0) && !m_ddp[dg] && ((m_disp >> (4*dg)) == 16'h0);
`endif
    if (ph < GUARD) begin
      e_seg = 7'h7F; e_an = 4'hF; e_dp = 1'b1;
    end else begin
      e_an  = ~(4'b0001 << dg);
      e_seg = blank ? 7'h7F : ~hex7[nib];
      e_dp  = ~m_ddp[dg];
    end
    e_tick = bnd;
    if (load) begin m_stage = value; m_sdp = dp_in; m_pend = 1'b1; end
    if (bnd && m_pend) begin m_disp = m_stage; m_ddp = m_sdp; m_pend = 1'b0; end
    m_t++;
  endtask

  task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] d);
    load = ld; value = v; dp_in = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    load = 1'b0;
    chk("seg", {25'd0, seg}, {25'd0, e_seg});
    chk("an", {28'd0, an}, {28'd0, e_an});
    chk("dp", {31'd0, dp}, {31'd0, e_dp});
    chk("frame_tick", {31'd0, frame_tick}, {31'd0, e_tick});
    chk("pending", {31'd0, pending}, {31'd0, m_pend});
    for (int i = 0; i < 4; i++)
      if (an[i] == 1'b0) begin
        obs_seg[i] = seg;
        obs_dp[i]  = dp;
        if (seg == 7'h79) saw_one = 1'b1;
      end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step(1'b0, value, dp_in);
  endtask

  task automatic wait_phase(input int p);
    int k;
    k = 0;
    while ((m_t % FRAME) != p && k < 2 * FRAME) begin
      step(1'b0, value, dp_in);
      k++;
    end
    if ((m_t % FRAME) != p) chk("wait_phase_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    saw_one = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_dp", {31'd0, dp}, 32'h1);
    chk("rst_pending", {31'd0, pending}, 32'h0);
    chk("rst_tick", {31'd0, frame_tick}, 32'h0);
    reset_n = 1'b1;

    run(2 * FRAME + 4);
    for (int d = 0; d < 4; d++) chk($sformatf("zero_d%0d", d), {25'd0, obs_seg[d]}, {25'd0, zero_digit(d)});

    wait_phase(5);
    step(1'b1, 16'h12AF, 4'b0100);
    chk("pend_after_load", {31'd0, pending}, 32'h1);
    wait_phase(0);
    chk("pend_after_bnd", {31'd0, pending}, 32'h0);
    run(FRAME);
    chk("f12af_d0", {25'd0, obs_seg[0]}, 32'h0E);
    chk("f12af_d1", {25'd0, obs_seg[1]}, 32'h08);
    chk("f12af_d2", {25'd0, obs_seg[2]}, 32'h24);
    chk("f12af_d3", {25'd0, obs_seg[3]}, 32'h79);
    chk("f12af_dp2", {31'd0, obs_dp[2]}, 32'h0);
    chk("f12af_dp0", {31'd0, obs_dp[0]}, 32'h1);

    wait_phase(2);
    step(1'b1, 16'h1111, 4'h0);
    run(3);
    step(1'b1, 16'h2222, 4'h0);
    wait_phase(0);
    saw_one = 1'b0;
    run(2 * FRAME);
    chk("no_1111_frame", {31'd0, saw_one}, 32'h0);
    for (int d = 0; d < 4; d++) chk($sformatf("f2222_d%0d", d), {25'd0, obs_seg[d]}, 32'h24);

    wait_phase(FRAME - 1);
    step(1'b1, 16'h0005, 4'h0);
    chk("bnd_load_pend", {31'd0, pending}, 32'h0);
    run(FRAME);
    chk("bnd_load_d0", {25'd0, obs_seg[0]}, 32'h12);

`ifdef SSEG_LZ_BLANK_EN
    wait_phase(3);
    step(1'b1, 16'h0030, 4'h0);
    wait_phase(0);
    run(FRAME);
    chk("lz_d3", {25'd0, obs_seg[3]}, 32'h7F);
    chk("lz_d2", {25'd0, obs_seg[2]}, 32'h7F);
    chk("lz_d1", {25'd0, obs_seg[1]}, 32'h30);
    chk("lz_d0", {25'd0, obs_seg[0]}, 32'h40);
`endif

    for (int k = 0; k < 300; k++)
      step($urandom_range(0, 7) == 0, 16'($urandom), 4'($urandom));

    wait_phase(3);
    step(1'b1, 16'hABCD, 4'hF);
    run(2);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_seg", {25'd0, seg}, 32'h7F);
    chk("arst_an", {28'd0, an}, 32'hF);
    chk("arst_dp", {31'd0, dp}, 32'h1);
    chk("arst_pending", {31'd0, pending}, 32'h0);
    chk("arst_tick", {31'd0, frame_tick}, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run(2 * FRAME);
    for (int d = 0; d < 4; d++) chk($sformatf("post_rst_d%0d", d), {25'd0, obs_seg[d]}, {25'd0, zero_digit(d)});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
